dac_ch_scheduler: RTL



---
 rtl/dac_pkg.sv | 41 ++++
 rtl/dac_ch_scheduler.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/dac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dac_pkg
// Description : Shared types and command-word layout for the MCP4822 channel
//               scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package dac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    localparam int CMD_CH       = 15;
    localparam int CMD_BUF      = 14;
    localparam int CMD_GA_N     = 13;
    localparam int CMD_SHDN_N   = 12;
    localparam int CMD_CODE_MSB = 11;
    localparam int CMD_CODE_LSB = 0;

    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

    localparam int SHADOW_W = 14;

    // Shadow layout is {ga_n, shdn_n, code}, which lines up with bits 13:0.
    function automatic logic [15:0] build_cmd(input logic ch, input logic buf_bit,
                                              input logic [SHADOW_W-1:0] shadow);
        logic [15:0] cmd;
        cmd                              = '0;
        cmd[CMD_CH]                      = ch;
        cmd[CMD_BUF]                     = buf_bit;
        cmd[CMD_GA_N:CMD_CODE_LSB]       = shadow;
        return cmd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dac_ch_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dac_ch_scheduler
// Description : Round-robin frame sequencer for the MCP4822 SPI DAC driver with
//               shadow setpoints, watchdog and inter-frame gap.
// Revision    : 1.0 - initial release
// ============================================================================
module dac_ch_scheduler
    import dac_pkg::*;
#(
    parameter int   GAP_CYC     = 4,
    parameter int   TIMEOUT_CYC = 255,
    parameter logic BUF_BIT     = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic        upd_ch,
    input  logic [11:0] upd_code,
    input  logic        upd_ga_n,
    input  logic        upd_shdn_n,
    input  logic        err_clr,
    output logic        drv_start,
    output logic [15:0] drv_data,
    input  logic        drv_done,
    output logic        busy,
    output logic [1:0]  pend,
    output logic        frame_done,
    output logic        frame_ch,
    output logic        err_timeout
);

    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 2);
    localparam logic [WD_W-1:0]  c_WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [GAP_W-1:0] c_GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SHADOW_W-1:0] r_shadow [2];
    logic [1:0]          r_pend;
    logic [1:0]          w_pend_nxt;
    logic                r_last_ch;
    logic [WD_W-1:0]     r_wd_cnt;
    logic [GAP_W-1:0]    r_gap_cnt;

    logic w_accept;
    logic w_launch;
    logic w_sel;
    logic w_done_hit;
    logic w_expire;

    assign upd_ready = ~err_timeout;
    assign busy      = (r_state != ST_IDLE);
    assign pend      = r_pend;
    assign w_accept  = upd_valid & upd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_launch) w_state_nxt = ST_LAUNCH;
            ST_LAUNCH: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (w_done_hit) begin
                    w_state_nxt = (GAP_CYC > 0) ? ST_GAP : ST_IDLE;
                end else if (w_expire) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GAP:    if (r_gap_cnt == c_GAP_LAST) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Control strobes; a tie between both channels goes to the one not served last.
    always_comb begin
        w_sel      = CH_A;
        w_launch   = 1'b0;
        w_done_hit = 1'b0;
        w_expire   = 1'b0;
        case (r_pend)
            2'b01:   w_sel = CH_A;
            2'b10:   w_sel = CH_B;
            2'b11:   w_sel = ~r_last_ch;
            default: w_sel = CH_A;
        endcase
        if (r_state == ST_IDLE) begin
            w_launch = enable & (|r_pend) & ~err_timeout;
        end
        if (r_state == ST_WAIT) begin
            w_done_hit = drv_done;
            w_expire   = ~drv_done & (r_wd_cnt == c_WD_LAST);
        end
    end

    // Sets are applied after the launch clear so a colliding update stays pending.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_launch) w_pend_nxt[w_sel]     = 1'b0;
        if (w_expire) w_pend_nxt[r_last_ch] = 1'b1;
        if (w_accept) w_pend_nxt[upd_ch]    = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow[0] <= '0;
            r_shadow[1] <= '0;
            r_pend      <= '0;
            r_last_ch   <= CH_B;
            r_wd_cnt    <= '0;
            r_gap_cnt   <= '0;
            drv_start   <= 1'b0;
            drv_data    <= '0;
            frame_done  <= 1'b0;
            frame_ch    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            r_pend     <= w_pend_nxt;
            drv_start  <= w_launch;
            frame_done <= w_done_hit;
            if (w_accept) begin
                r_shadow[upd_ch] <= {upd_ga_n, upd_shdn_n, upd_code};
            end
            if (w_launch) begin
                drv_data  <= build_cmd(w_sel, BUF_BIT, r_shadow[w_sel]);
                r_last_ch <= w_sel;
            end
            if (r_state == ST_LAUNCH) begin
                r_wd_cnt <= '0;
            end else if (r_state == ST_WAIT) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
            if (w_done_hit) begin
                frame_ch  <= r_last_ch;
                r_gap_cnt <= '0;
            end else if (r_state == ST_GAP) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end
            if (w_expire) begin
                err_timeout <= 1'b1;
            end else if (err_clr) begin
                err_timeout <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
